mskaes_128bits_round_core: RTL and testbench
============================================

# mskaes_128bits_round_core

Masked AES-128 round datapath and controller that sits directly downstream of the masked 16-byte SubBytes layer. It owns the shared state register and drives the SubBytes layer from it. It waits out the S-box pipeline latency, then applies ShiftRows, MixColumns and AddRoundKey share-wise to the SubBytes output and writes the result back. It sequences 10 rounds per block behind a valid/ready handshake on input and output.

## Interface
- `d`, 2, number of Boolean shares (d ≥ 2).
- `SB_LAT`, 4, cycles from `sh_sb_in` being presented to the matching `sh_sb_out` (must match the S-box layer instance, ≥ 1).
- `clk` in 1: the single clock; everything is rising-edge.
- `nrst` in 1: synchronous, active-high reset. Reset is taken when `nrst`=1 at a rising edge.
- `in_valid` in 1: plaintext shares valid.
- `in_ready` out 1: block accepts plaintext.
- `sh_plain_in` in 128*d: shared plaintext.
- `sh_rkey` in 128*d: shared round key selected by `rkey_idx`.
- `rkey_idx` out 4: round-key index requested (0..10).
- `sh_sb_in` out 128*d: to SubBytes layer input.
- `sh_sb_out` in 128*d: from SubBytes layer output.
- `out_valid` out 1: ciphertext shares valid.
- `out_ready` in 1: consumer accepts ciphertext.
- `sh_cipher_out` out 128*d: shared ciphertext.

Layout for all 128*d buses:
- Byte i (AES byte order; i=0 is first input byte, row i%4, column i/4) occupies bits [8*d*i +: 8*d].
- Share j of that byte occupies [8*d*i + 8*j +: 8].
- The unmasked value is the XOR of all shares.

## Operation
- FSM states: IDLE, SBWAIT, LIN, DONE.
- Registers: shared state `st` (128*d), round counter `rnd` (4 bit, 0..10), latency counter `cnt`.
- `sh_sb_in` = `st` directly, with no logic between. `st` is held constant during SBWAIT.
- IDLE:
  - `in_ready`=1, `rkey_idx`=0.
  - On `in_valid`&`in_ready`: `st` ← `sh_plain_in` ^ `sh_rkey` share-wise, `rnd` ← 1, `cnt` ← 0, go to SBWAIT.
- SBWAIT:
  - `cnt` increments each cycle.
  - When `cnt`=SB_LAT-1, go to LIN.
- LIN (one cycle):
  - `st` ← ARK(MC(SR(`sh_sb_out`)), `sh_rkey`).
  - MC is skipped when `rnd`=10.
  - If `rnd`=10, go to DONE. Otherwise `rnd` ← `rnd`+1, `cnt` ← 0, go to SBWAIT.
- `rkey_idx` = `rnd` in SBWAIT/LIN. The key source must present a stable `sh_rkey` for the whole round; it is sampled only in LIN (and on the IDLE accept cycle).
- DONE:
  - `out_valid`=1, `sh_cipher_out` = `st`.
  - Both are held unchanged until `out_valid`&`out_ready`, then go to IDLE.
- `sh_cipher_out` = `st` at all times. It is qualified only by `out_valid`.
- Masking rules:
  - SR, MC and ARK are applied to each share independently: share j of the output depends only on share j of the inputs.
  - Shares are never XORed together. No randomness is consumed.
- MC per share uses GF(2^8) with polynomial 0x11B: xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- `in_valid` while not in IDLE is ignored; `in_ready`=0 outside IDLE.

## Timing
- Reset values:
  - FSM=IDLE, `st`=0, `rnd`=0, `cnt`=0.
  - `out_valid`=0, `sh_sb_in`=0, `sh_cipher_out`=0, `rkey_idx`=0.
  - `in_ready`=0 during any cycle with `nrst`=1, and 1 on the first cycle after.
- Reset mid-operation aborts the block immediately: no output and no partial `out_valid`.
- Each round takes SB_LAT+1 cycles.
- Latency: accept edge to `out_valid`=1 is 1 + 10*(SB_LAT+1) cycles. This is 51 for SB_LAT=4.
- Simultaneous `out_valid`&`out_ready`: the handshake completes that edge and `in_ready`=1 on the next cycle. There is no same-cycle input accept in DONE.
- Throughput: one block per 52 cycles minimum (SB_LAT=4, `out_ready` held 1).
- `rkey_idx` changes only on the IDLE→SBWAIT edge and on LIN edges.

## Test plan
- **FIPS-197 C.1, d=2:**
  - Stimulus: key 000102…0f, pt 00112233445566778899aabbccddeeff, random share split per block, real S-box layer with SB_LAT=4.
  - Required: unmasked `sh_cipher_out` = 69c4e0d86a7b0430d8cdb78070b4c55a, with `out_valid` exactly 51 cycles after accept.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0 for 7 cycles after `out_valid`.
  - Required: `out_valid` and `sh_cipher_out` stay constant and `in_ready`=0 throughout. `in_ready`=1 the cycle after `out_ready`=1.
- **Busy input:**
  - Stimulus: pulse `in_valid` with a different pt at cycles 5 and 30 of a block.
  - Required: both pulses are ignored and the first block's ciphertext is unchanged.
- **Reset mid-round:**
  - Stimulus: `nrst`=1 for one cycle at cycle 20.
  - Required: next cycle FSM=IDLE, `st`=0, `out_valid`=0, `rkey_idx`=0. A fresh C.1 block afterwards yields the correct ciphertext.
- **Share independence:**
  - Stimulus: run the same pt/key with 1000 random share splits.
  - Required: the unmasked ciphertext is identical every time, and each output share changes with its input share split.
- **Parameter sweep:**
  - Stimulus: d=3 with SB_LAT=6 (behavioural S-box model of matching latency).
  - Required: correct C.1 ciphertext with `out_valid` at 71 cycles.

Source files
------------

// File: rtl/mskaes_128bits_round_core_if.sv
// Bundle for the masked AES round core: plaintext/ciphertext handshakes, round-key fetch and the
// SubBytes layer feed/return path. All wide buses carry D Boolean shares per byte.
interface mskaes_128bits_round_core_if #(
    parameter int unsigned D = 2
);
    localparam int unsigned W = 128 * D;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sh_plain_in;
    logic [W-1:0] sh_rkey;
    logic [3:0]   rkey_idx;
    logic [W-1:0] sh_sb_in;
    logic [W-1:0] sh_sb_out;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sh_cipher_out;

    // Core side.
    modport slave (
        input  in_valid, sh_plain_in, sh_rkey, sh_sb_out, out_ready,
        output in_ready, rkey_idx, sh_sb_in, out_valid, sh_cipher_out
    );

    // Environment side: plaintext source, key store, S-box layer, ciphertext sink.
    modport master (
        output in_valid, sh_plain_in, sh_rkey, sh_sb_out, out_ready,
        input  in_ready, rkey_idx, sh_sb_in, out_valid, sh_cipher_out
    );
endinterface

// File: rtl/mskaes_128bits_round_core.sv
// Masked AES-128 round controller: owns the shared state, feeds the external masked SubBytes layer
// and applies ShiftRows, MixColumns and AddRoundKey to each share independently.
module mskaes_128bits_round_core #(
    parameter int unsigned D     = 2,
    parameter int unsigned SbLat = 4
) (
    input logic                        clk_i,
    input logic                        nrst_i,
    mskaes_128bits_round_core_if.slave bus_io
);
    localparam int unsigned     W       = 128 * D;
    localparam int unsigned     CntW    = (SbLat > 1) ? $clog2(SbLat) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SbLat - 1);
    localparam logic [3:0]      LastRnd = 4'd10;

    typedef enum logic [1:0] {StIdle, StSbWait, StLin, StDone} state_e;

    state_e          state_q;
    logic [W-1:0]    st_q;
    logic [3:0]      rnd_q;
    logic [CntW-1:0] cnt_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [W-1:0]    lin_d;

    logic [15:0][7:0] sr_b;
    logic [15:0][7:0] mc_b;
    logic [7:0]       a0, a1, a2, a3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Share j of every output byte is built from share j of the S-box output and round key only.
    always_comb begin
        lin_d = '0;
        sr_b  = '0;
        mc_b  = '0;
        a0    = '0;
        a1    = '0;
        a2    = '0;
        a3    = '0;
        for (int unsigned j = 0; j < D; j++) begin
            for (int unsigned i = 0; i < 16; i++) begin
                sr_b[i] = bus_io.sh_sb_out[8*D*(4*(((i/4) + (i%4)) % 4) + (i%4)) + 8*j +: 8];
            end
            for (int unsigned c = 0; c < 4; c++) begin
                a0 = sr_b[4*c];
                a1 = sr_b[4*c+1];
                a2 = sr_b[4*c+2];
                a3 = sr_b[4*c+3];
                if (rnd_q == LastRnd) begin
                    mc_b[4*c]   = a0;
                    mc_b[4*c+1] = a1;
                    mc_b[4*c+2] = a2;
                    mc_b[4*c+3] = a3;
                end else begin
                    mc_b[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    mc_b[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    mc_b[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    mc_b[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            for (int unsigned i = 0; i < 16; i++) begin
                lin_d[8*D*i + 8*j +: 8] = mc_b[i] ^ bus_io.sh_rkey[8*D*i + 8*j +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (nrst_i) begin
            state_q     <= StIdle;
            st_q        <= '0;
            rnd_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        st_q       <= bus_io.sh_plain_in ^ bus_io.sh_rkey;
                        rnd_q      <= 4'd1;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StSbWait;
                    end
                end
                StSbWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q <= StLin;
                    end
                end
                StLin: begin
                    st_q <= lin_d;
                    if (rnd_q == LastRnd) begin
                        // Key index returns to 0 here so it is already correct back in idle.
                        rnd_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        rnd_q   <= rnd_q + 4'd1;
                        cnt_q   <= '0;
                        state_q <= StSbWait;
                    end
                end
                StDone: begin
                    if (bus_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Ready is masked by reset so no accept can be advertised during a reset cycle.
    assign bus_io.in_ready      = in_ready_q & ~nrst_i;
    assign bus_io.out_valid     = out_valid_q;
    assign bus_io.rkey_idx      = rnd_q;
    assign bus_io.sh_sb_in      = st_q;
    assign bus_io.sh_cipher_out = st_q;

endmodule

// File: tb/tb_mskaes_128bits_round_core.sv
// Scoreboard bench for the masked AES round core: behavioural masked S-box layers, an unmasked
// AES-128 reference, and a monitor that checks every ciphertext and its latency.
module tb_mskaes_128bits_round_core;
    localparam int unsigned Lat2 = 4;
    localparam int unsigned Lat3 = 6;
    localparam int          ExpLat2 = 1 + 10 * (Lat2 + 1);
    localparam int          ExpLat3 = 1 + 10 * (Lat3 + 1);

    logic clk;
    logic nrst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    mskaes_128bits_round_core_if #(.D(2)) bus ();
    mskaes_128bits_round_core_if #(.D(3)) bus3 ();

    mskaes_128bits_round_core #(.D(2), .SbLat(Lat2)) u_dut (
        .clk_i  (clk),
        .nrst_i (nrst),
        .bus_io (bus)
    );

    mskaes_128bits_round_core #(.D(3), .SbLat(Lat3)) u_dut3 (
        .clk_i  (clk),
        .nrst_i (nrst),
        .bus_io (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = s;
        end
    end

    // Values are in FIPS-197 text order: byte 0 is the most significant byte.
    function automatic logic [127:0] sub_all(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_t[v[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = rk;
        t = {w3[23:0], w3[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   m [4][4];
        logic [7:0]   n [4][4];
        logic [127:0] s, rk;
        logic [7:0]   rcon;
        rk = key;
        s = pt ^ key;
        rcon = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            s = sub_all(s);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) m[row][c] = s[127-8*(4*c+row) -: 8];
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++) n[row][c] = m[row][(c + row) % 4];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    m[0][c] = gmul(8'h02, n[0][c]) ^ gmul(8'h03, n[1][c]) ^ n[2][c] ^ n[3][c];
                    m[1][c] = n[0][c] ^ gmul(8'h02, n[1][c]) ^ gmul(8'h03, n[2][c]) ^ n[3][c];
                    m[2][c] = n[0][c] ^ n[1][c] ^ gmul(8'h02, n[2][c]) ^ gmul(8'h03, n[3][c]);
                    m[3][c] = gmul(8'h03, n[0][c]) ^ n[1][c] ^ n[2][c] ^ gmul(8'h02, n[3][c]);
                end
                n = m;
            end
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[127-8*(4*c+row) -: 8] = n[row][c];
            rk = next_rk(rk, rcon);
            rcon = gmul(rcon, 8'h02);
            s = s ^ rk;
        end
        return s;
    endfunction

    function automatic logic [383:0] mask_state(input logic [127:0] v, input int ns);
        logic [383:0] b;
        logic [7:0]   acc;
        logic [7:0]   rnd;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            acc = v[127-8*i -: 8];
            for (int j = 0; j < ns - 1; j++) begin
                rnd = 8'($urandom);
                b[8*ns*i + 8*j +: 8] = rnd;
                acc = acc ^ rnd;
            end
            b[8*ns*i + 8*(ns-1) +: 8] = acc;
        end
        return b;
    endfunction

    function automatic logic [127:0] unmask(input logic [383:0] b, input int ns);
        logic [127:0] v;
        logic [7:0]   x;
        for (int i = 0; i < 16; i++) begin
            x = 8'h00;
            for (int j = 0; j < ns; j++) x = x ^ b[8*ns*i + 8*j +: 8];
            v[127-8*i -: 8] = x;
        end
        return v;
    endfunction

    function automatic logic [127:0] share_of(input logic [383:0] b, input int ns, input int j);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = b[8*ns*i + 8*j +: 8];
        return v;
    endfunction

    // ---------------- environment: key stores and masked S-box layers ----------------
    logic [255:0] rk2 [11];
    logic [383:0] rk3 [11];
    logic [255:0] pipe2 [Lat2];
    logic [383:0] pipe3 [Lat3];

    always_comb bus.sh_rkey = (bus.rkey_idx <= 4'd10) ? rk2[bus.rkey_idx] : '0;
    always_comb bus3.sh_rkey = (bus3.rkey_idx <= 4'd10) ? rk3[bus3.rkey_idx] : '0;

    // Fresh output masks every cycle, fixed pipeline depth.
    always @(posedge clk) begin
        pipe2[0] <= 256'(mask_state(sub_all(unmask(384'(bus.sh_sb_in), 2)), 2));
        for (int k = 1; k < int'(Lat2); k++) pipe2[k] <= pipe2[k-1];
        pipe3[0] <= mask_state(sub_all(unmask(bus3.sh_sb_in, 3)), 3);
        for (int k = 1; k < int'(Lat3); k++) pipe3[k] <= pipe3[k-1];
    end
    assign bus.sh_sb_out  = pipe2[Lat2-1];
    assign bus3.sh_sb_out = pipe3[Lat3-1];

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] ct;
        int           lat;
        bit           ck_share;
    } exp_t;

    exp_t         exp_q [$];
    exp_t         e;
    bit           seen;
    bit           hs_prev;
    bit           have_prev;
    int           acc_cyc;
    logic [255:0] held;
    logic [255:0] prev_ct;

    always @(negedge clk) begin
        if (nrst) begin
            seen    = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) chk("in_ready_after_handshake", 384'(bus.in_ready), 384'(1));
            hs_prev = 1'b0;
            if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
            if (bus.out_valid) begin
                chk("in_ready_while_done", 384'(bus.in_ready), 384'(0));
                if (!seen) begin
                    seen = 1'b1;
                    held = bus.sh_cipher_out;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %h expected none",
                                 bus.sh_cipher_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ciphertext", 384'(unmask(384'(bus.sh_cipher_out), 2)), 384'(e.ct));
                        chk("latency", 384'(cyc - acc_cyc), 384'(e.lat));
                        if (e.ck_share) begin
                            if (have_prev) begin
                                for (int j = 0; j < 2; j++) begin
                                    n_checks++;
                                    if (share_of(384'(bus.sh_cipher_out), 2, j)
                                        == share_of(384'(prev_ct), 2, j)) begin
                                        n_fail++;
                                        $display("FAIL share_change: share %0d got %h expected a new value",
                                                 j, share_of(384'(bus.sh_cipher_out), 2, j));
                                    end
                                end
                            end
                            prev_ct = bus.sh_cipher_out;
                            have_prev = 1'b1;
                        end
                    end
                end else begin
                    chk("cipher_hold", 384'(bus.sh_cipher_out), 384'(held));
                end
                if (bus.out_ready) begin
                    seen = 1'b0;
                    hs_prev = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    task automatic load_keys2(input logic [127:0] key);
        logic [127:0] rk;
        logic [7:0]   rcon;
        rk = key;
        rcon = 8'h01;
        for (int r = 0; r <= 10; r++) begin
            rk2[r] = 256'(mask_state(rk, 2));
            rk = next_rk(rk, rcon);
            rcon = gmul(rcon, 8'h02);
        end
    endtask

    task automatic start_block(input logic [127:0] key, input logic [127:0] pt,
                               input logic [127:0] ct, input bit ck_share);
        exp_t x;
        bit   ok;
        load_keys2(key);
        @(posedge clk);
        #1;
        bus.sh_plain_in = 256'(mask_state(pt, 2));
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else @(posedge clk);
        end
        chk("accept_timeout", 384'(ok), 384'(1));
        if (ok) begin
            x.ct = ct;
            x.lat = ExpLat2;
            x.ck_share = ck_share;
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_timeout", 384'(exp_q.size()), 384'(0));
        exp_q.delete();
    endtask

    task automatic busy_pulse(input logic [127:0] pt);
        @(posedge clk);
        #1;
        bus.sh_plain_in = 256'(mask_state(pt, 2));
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready_busy", 384'(bus.in_ready), 384'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_d3(input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] ct);
        logic [127:0] rk;
        logic [7:0]   rcon;
        int           acc3;
        bit           got;
        rk = key;
        rcon = 8'h01;
        for (int r = 0; r <= 10; r++) begin
            rk3[r] = mask_state(rk, 3);
            rk = next_rk(rk, rcon);
            rcon = gmul(rcon, 8'h02);
        end
        @(posedge clk);
        #1;
        bus3.sh_plain_in = mask_state(pt, 3);
        bus3.in_valid = 1'b1;
        @(negedge clk);
        chk("d3_in_ready", 384'(bus3.in_ready), 384'(1));
        acc3 = cyc;
        @(posedge clk);
        #1;
        bus3.in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 150 && !got; k++) begin
            @(negedge clk);
            if (bus3.out_valid) got = 1'b1;
        end
        chk("d3_out_valid_seen", 384'(got), 384'(1));
        if (got) begin
            chk("d3_latency", 384'(cyc - acc3), 384'(ExpLat3));
            chk("d3_ciphertext", 384'(unmask(bus3.sh_cipher_out, 3)), 384'(ct));
        end
        @(posedge clk);
    endtask

    initial begin
        logic [127:0] key;
        logic [127:0] pt;
        bit           got;
        n_checks = 0;
        n_fail = 0;
        have_prev = 1'b0;
        seen = 1'b0;
        hs_prev = 1'b0;
        acc_cyc = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.sh_plain_in = '0;
        bus3.in_valid = 1'b0;
        bus3.out_ready = 1'b1;
        bus3.sh_plain_in = '0;
        for (int r = 0; r <= 10; r++) begin
            rk2[r] = '0;
            rk3[r] = '0;
        end
        nrst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", 384'(bus.in_ready), 384'(0));
        @(posedge clk);
        #1;
        nrst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 384'(bus.in_ready), 384'(1));
        chk("rst_out_valid", 384'(bus.out_valid), 384'(0));
        chk("rst_sb_in", 384'(bus.sh_sb_in), 384'(0));
        chk("rst_cipher", 384'(bus.sh_cipher_out), 384'(0));
        chk("rst_rkey_idx", 384'(bus.rkey_idx), 384'(0));

        // Wider sharing and longer S-box pipeline on the second instance.
        run_d3(C1Key, C1Pt, C1Ct);
        key = {$urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom, $urandom, $urandom};
        run_d3(key, pt, aes_ref(key, pt));

        start_block(C1Key, C1Pt, C1Ct, 1'b0);
        wait_drain();

        // Backpressure.
        key = {$urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom, $urandom, $urandom};
        bus.out_ready = 1'b0;
        start_block(key, pt, aes_ref(key, pt), 1'b0);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.out_valid) got = 1'b1;
        end
        chk("bp_out_valid_seen", 384'(got), 384'(1));
        repeat (7) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drain();

        // Busy input pulses must not disturb the running block.
        start_block(C1Key, C1Pt, C1Ct, 1'b0);
        repeat (3) @(posedge clk);
        busy_pulse(~C1Pt);
        repeat (23) @(posedge clk);
        busy_pulse(C1Pt ^ 128'h1);
        wait_drain();

        // Reset mid-round.
        start_block(C1Key, C1Pt, C1Ct, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        nrst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("in_ready_mid_reset", 384'(bus.in_ready), 384'(0));
        @(posedge clk);
        #1;
        nrst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 384'(bus.out_valid), 384'(0));
        chk("abort_rkey_idx", 384'(bus.rkey_idx), 384'(0));
        chk("abort_state", 384'(bus.sh_sb_in), 384'(0));
        chk("abort_in_ready", 384'(bus.in_ready), 384'(1));
        start_block(C1Key, C1Pt, C1Ct, 1'b0);
        wait_drain();

        for (int n = 0; n < 8; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            start_block(key, pt, aes_ref(key, pt), 1'b0);
            wait_drain();
        end

        // Same secret, fresh share splits every block.
        for (int n = 0; n < 1000; n++) begin
            start_block(C1Key, C1Pt, C1Ct, 1'b1);
            wait_drain();
        end

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
